// File: rtl/upower_decode_stage_pkg.sv
// upower_pkg: opcode/extended-opcode constants, format codes and the decoded
// field bundle shared by the decode stage and its field decoder.
// Latency: n/a (declarations only). Backpressure: n/a.
package upower_pkg;

  // Field widths of the decoded bundle
  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int SI_W     = 16;
  localparam int DS_W     = 14;
  localparam int XODS_W   = 2;
  localparam int XOX_W    = 10;
  localparam int XOXO_W   = 9;
  localparam int FMT_W    = 3;

  // Primary opcodes
  localparam logic [5:0] OP_ADDI  = 6'd14;
  localparam logic [5:0] OP_ADDIS = 6'd15;
  localparam logic [5:0] OP_I     = 6'd18;
  localparam logic [5:0] OP_B     = 6'd19;
  localparam logic [5:0] OP_ORI   = 6'd24;
  localparam logic [5:0] OP_XORI  = 6'd26;
  localparam logic [5:0] OP_ANDI  = 6'd28;
  localparam logic [5:0] OP_X     = 6'd31;
  localparam logic [5:0] OP_LWZ   = 6'd32;
  localparam logic [5:0] OP_LBZ   = 6'd34;
  localparam logic [5:0] OP_STW   = 6'd36;
  localparam logic [5:0] OP_STWU  = 6'd37;
  localparam logic [5:0] OP_STB   = 6'd38;
  localparam logic [5:0] OP_LHZ   = 6'd40;
  localparam logic [5:0] OP_LHA   = 6'd42;
  localparam logic [5:0] OP_STH   = 6'd44;
  localparam logic [5:0] OP_LD    = 6'd58;
  localparam logic [5:0] OP_STD   = 6'd62;

  // XO-form extended opcodes (instr[9:1])
  localparam logic [8:0] XO_ADD  = 9'd266;
  localparam logic [8:0] XO_SUBF = 9'd40;

  // X-form extended opcodes (instr[10:1])
  localparam logic [9:0] X_AND   = 10'd28;
  localparam logic [9:0] X_NAND  = 10'd476;
  localparam logic [9:0] X_OR    = 10'd444;
  localparam logic [9:0] X_XOR   = 10'd316;
  localparam logic [9:0] X_EXTSW = 10'd986;

  // Format codes
  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_XO   = 3'd1;
  localparam logic [2:0] FMT_X    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_I    = 3'd4;
  localparam logic [2:0] FMT_D    = 3'd5;
  localparam logic [2:0] FMT_DS   = 3'd6;
  localparam logic [2:0] FMT_ILL  = 3'd7;

  // Encoding equals queue occupancy; the top relies on this.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    bo;
    logic [REG_W-1:0]    bi;
    logic [SI_W-1:0]     si;
    logic [DS_W-1:0]     ds;
    logic [XODS_W-1:0]   xods;
    logic [XOX_W-1:0]    xox;
    logic [XOXO_W-1:0]   xoxo;
    logic                aa;
    logic [FMT_W-1:0]    fmt;
    logic                illegal;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

  function automatic logic is_d_op(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_ADDIS, OP_ORI, OP_XORI, OP_ANDI, OP_LWZ, OP_LBZ,
      OP_STW, OP_STWU, OP_STB, OP_LHZ, OP_LHA, OP_STH: is_d_op = 1'b1;
      default:                                         is_d_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_x_legal(input logic [9:0] xo);
    case (xo)
      X_AND, X_NAND, X_OR, X_XOR, X_EXTSW: is_x_legal = 1'b1;
      default:                             is_x_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/upower_decode_stage_field_decode.sv
// upower_field_decode: splits one uPower word into the ALU field bundle.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: i_instr (32-bit word in), o_dec (packed dec_t bundle out).
module upower_field_decode
  import upower_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output logic [DEC_W-1:0]   o_dec
);

  dec_t       w_dec;
  logic [5:0] w_op;
  logic       w_known;

  assign w_op    = i_instr[31:26];
  assign w_known = (w_op == OP_X) || (w_op == OP_B) || (w_op == OP_I) ||
                   is_d_op(w_op) || (w_op == OP_LD) || (w_op == OP_STD);

  // Every format-specific field starts at zero so the ALU's "field != 0"
  // tests only fire for the format that actually owns the field.
  always_comb begin
    w_dec         = '0;
    w_dec.opcode  = w_op;
    w_dec.fmt     = FMT_ILL;
    w_dec.illegal = 1'b1;
    if (w_known) begin
      w_dec.illegal = 1'b0;
      w_dec.rd      = i_instr[25:21];
      w_dec.rs      = i_instr[20:16];
      w_dec.rt      = i_instr[15:11];
    end
    if (w_op == OP_X) begin
      if ((i_instr[9:1] == XO_ADD) || (i_instr[9:1] == XO_SUBF)) begin
        w_dec.fmt  = FMT_XO;
        w_dec.xoxo = i_instr[9:1];
      end else begin
        // Unknown X-form keeps its fields but is flagged undecodable
        w_dec.fmt     = FMT_X;
        w_dec.xox     = i_instr[10:1];
        w_dec.illegal = !is_x_legal(i_instr[10:1]);
      end
    end else if (w_op == OP_B) begin
      w_dec.fmt = FMT_B;
      w_dec.bo  = i_instr[25:21];
      w_dec.bi  = i_instr[20:16];
      w_dec.aa  = i_instr[1];
    end else if (w_op == OP_I) begin
      w_dec.fmt = FMT_I;
    end else if ((w_op == OP_LD) || (w_op == OP_STD)) begin
      w_dec.fmt  = FMT_DS;
      w_dec.ds   = i_instr[15:2];
      w_dec.xods = i_instr[1:0];
    end else if (is_d_op(w_op)) begin
      w_dec.fmt = FMT_D;
      w_dec.si  = i_instr[15:0];
    end
  end

  assign o_dec = w_dec;

endmodule

// File: rtl/upower_decode_stage.sv
// upower_decode_stage: registered decode stage, fetch words -> ALU bundles.
// Latency: 1 cycle from accept to bundle on outputs.
// Backpressure: 2-entry skid queue; o_in_ready is registered (queue not full).
// Ports: i_clk, i_rst_n (async low), i_flush; fetch side i_in_valid/o_in_ready/
//   i_in_instr; execute side o_out_valid/i_out_ready plus decoded fields,
//   o_fmt, o_illegal, o_tag. Optional UPOWER_DECODE_STATS_EN adds o_stat_ops
//   and o_stat_ill (saturating accepted/illegal word counters).
module upower_decode_stage
  import upower_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_instr,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [5:0]       o_opcode,
  output logic [4:0]       o_rd,
  output logic [4:0]       o_rs,
  output logic [4:0]       o_rt,
  output logic [4:0]       o_bo,
  output logic [4:0]       o_bi,
  output logic [15:0]      o_si,
  output logic [13:0]      o_ds,
  output logic [1:0]       o_xods,
  output logic [9:0]       o_xox,
  output logic [8:0]       o_xoxo,
  output logic             o_aa,
  output logic [2:0]       o_fmt,
  output logic             o_illegal,
  output logic [TAG_W-1:0] o_tag
`ifdef UPOWER_DECODE_STATS_EN
  ,
  output logic [31:0]      o_stat_ops,
  output logic [31:0]      o_stat_ill
`endif
);

  occ_state_t       r_state;
  occ_state_t       w_state_nxt;
  logic             r_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic [DEC_W-1:0] w_dec_raw;
  dec_t             w_dec;
  dec_t             r_head;
  dec_t             r_tail;
  logic [TAG_W-1:0] r_head_tag;
  logic [TAG_W-1:0] r_tail_tag;
  logic [TAG_W-1:0] r_tag_cnt;

  upower_field_decode u_field_decode (
    .i_instr (i_in_instr),
    .o_dec   (w_dec_raw)
  );
  assign w_dec = dec_t'(w_dec_raw);

  // FSM: state register. in_ready is registered from the next state so
  // out_ready never reaches in_ready combinationally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (32'(w_state_nxt) != DEPTH);
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
        ST_ONE: begin
          if (w_push && !w_pop)      w_state_nxt = ST_TWO;
          else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
        end
        ST_TWO:   if (w_pop) w_state_nxt = ST_ONE;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // FSM: outputs. A flush cycle neither accepts nor retires anything.
  always_comb begin
    w_out_valid = (r_state != ST_EMPTY);
    w_push      = i_in_valid && r_in_ready && !i_flush;
    w_pop       = w_out_valid && i_out_ready && !i_flush;
  end

  // Queue storage: head always drives the outputs; tail shifts up on pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_head_tag <= '0;
      r_tail_tag <= '0;
    end else if (!i_flush) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_head     <= w_dec;
            r_head_tag <= r_tag_cnt;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            r_head     <= w_dec;
            r_head_tag <= r_tag_cnt;
          end else if (w_push) begin
            r_tail     <= w_dec;
            r_tail_tag <= r_tag_cnt;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            r_head     <= r_tail;
            r_head_tag <= r_tail_tag;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequence tag survives flush so execute can see the gap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag_cnt <= '0;
    end else if (w_push) begin
      r_tag_cnt <= r_tag_cnt + TAG_W'(1);
    end
  end

`ifdef UPOWER_DECODE_STATS_EN
  logic [31:0] r_stat_ops;
  logic [31:0] r_stat_ill;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stat_ops <= '0;
      r_stat_ill <= '0;
    end else if (w_push) begin
      if (r_stat_ops != '1)                  r_stat_ops <= r_stat_ops + 32'd1;
      if (w_dec.illegal && r_stat_ill != '1) r_stat_ill <= r_stat_ill + 32'd1;
    end
  end

  assign o_stat_ops = r_stat_ops;
  assign o_stat_ill = r_stat_ill;
`endif

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_opcode    = r_head.opcode;
  assign o_rd        = r_head.rd;
  assign o_rs        = r_head.rs;
  assign o_rt        = r_head.rt;
  assign o_bo        = r_head.bo;
  assign o_bi        = r_head.bi;
  assign o_si        = r_head.si;
  assign o_ds        = r_head.ds;
  assign o_xods      = r_head.xods;
  assign o_xox       = r_head.xox;
  assign o_xoxo      = r_head.xoxo;
  assign o_aa        = r_head.aa;
  assign o_fmt       = r_head.fmt;
  assign o_illegal   = r_head.illegal;
  assign o_tag       = r_head_tag;

endmodule
